// File: rtl/minmax_stream_reducer_if.sv
// Stream bundle for the min/max reducer: an input beat stream (valid/ready,
// data, last) and an output record stream (valid/ready, min, max, count).
//   master : drives beats in, consumes records (operand source / result sink side)
//   slave  : accepts beats, produces records (the reducer itself)
interface minmax_stream_reducer_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_min;
  logic [WIDTH-1:0] out_max;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_min, out_max, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_min, out_max, out_count
  );
endinterface

// File: rtl/minmax_stream_reducer.sv
// Reduces one packet of unsigned words to {min, max, beat count} and emits the
// record once per packet.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   s   : stream bundle (slave view) - beats in, record out
module minmax_stream_reducer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  minmax_stream_reducer_if.slave s
);
  typedef enum logic [1:0] {IDLE, ACC, OUT} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  // Gated by rst so no beat is taken in the reset cycle itself.
  assign s.in_ready  = (state_q != OUT) && !rst;
  assign s.out_valid = (state_q == OUT);
  // The running registers double as the record: frozen while in OUT.
  assign s.out_min   = min_q;
  assign s.out_max   = max_q;
  assign s.out_count = cnt_q;

  assign accept = s.in_valid && s.in_ready;

  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    max_d   = max_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          min_d   = s.in_data;
          max_d   = s.in_data;
          cnt_d   = CNT_W'(1);
          state_d = s.in_last ? OUT : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          // Strict compares: ties keep the stored value.
          if (s.in_data < min_q) min_d = s.in_data;
          if (s.in_data > max_q) max_d = s.in_data;
          if (cnt_q != CNT_MAX)  cnt_d = cnt_q + CNT_W'(1);
          if (s.in_last)         state_d = OUT;
        end
      end
      OUT: begin
        if (s.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      min_q   <= '0;
      max_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      max_q   <= max_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_minmax_stream_reducer.sv
module tb_minmax_stream_reducer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  minmax_stream_reducer_if #(.WIDTH(32), .CNT_W(16)) m ();
  minmax_stream_reducer_if #(.WIDTH(32), .CNT_W(4))  m4 ();

  // The narrow-counter instance sees the same stimulus as the main one.
  assign m4.in_valid  = m.in_valid;
  assign m4.in_data   = m.in_data;
  assign m4.in_last   = m.in_last;
  assign m4.out_ready = m.out_ready;

  minmax_stream_reducer #(.WIDTH(32), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .s(m.slave));
  minmax_stream_reducer #(.WIDTH(32), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .s(m4.slave));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Offer one beat; returns just after the edge at which it was accepted.
  task automatic send(input logic [31:0] d, input logic last);
    bit done = 0;
    m.in_valid = 1'b1; m.in_data = d; m.in_last = last;
    for (int k = 0; k < 20 && !done; k++) begin
      if (m.in_ready) done = 1;
      step();
    end
    m.in_valid = 1'b0;
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  // Record present now; with out_ready=1 it must be gone one cycle later.
  task automatic expect_rec(input string tag, input logic [31:0] mn, input logic [31:0] mx,
                            input logic [15:0] cnt);
    chk({tag, "_vld"}, 64'(m.out_valid), 64'd1);
    chk({tag, "_min"}, 64'(m.out_min), 64'(mn));
    chk({tag, "_max"}, 64'(m.out_max), 64'(mx));
    chk({tag, "_cnt"}, 64'(m.out_count), 64'(cnt));
    step();
    chk({tag, "_drop"}, 64'(m.out_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    m.in_valid = 1'b0; m.in_data = '0; m.in_last = 1'b0; m.out_ready = 1'b1;
    step();
    chk("rst_ready", 64'(m.in_ready), 64'd0);
    chk("rst_vld",   64'(m.out_valid), 64'd0);
    chk("rst_min",   64'(m.out_min), 64'd0);
    chk("rst_max",   64'(m.out_max), 64'd0);
    chk("rst_cnt",   64'(m.out_count), 64'd0);
    rst = 1'b0; #1;
    chk("post_rst_ready", 64'(m.in_ready), 64'd1);

    // One-beat packet: record the cycle after the last beat.
    send(32'd5, 1'b1);
    chk("one_ready", 64'(m.in_ready), 64'd0);
    expect_rec("one", 32'd5, 32'd5, 16'd1);

    // Unsigned extremes.
    send(32'd7, 1'b0); send(32'hFFFF_FFFF, 1'b0); send(32'd0, 1'b0); send(32'd7, 1'b1);
    expect_rec("ext", 32'd0, 32'hFFFF_FFFF, 16'd4);

    // Ties with idle gaps.
    send(32'd3, 1'b0); step(); step();
    send(32'd3, 1'b0); step(); step(); step();
    send(32'd3, 1'b1);
    expect_rec("tie", 32'd3, 32'd3, 16'd3);

    // Back-pressure: record held, offered beats refused.
    m.out_ready = 1'b0;
    send(32'd10, 1'b0); send(32'd2, 1'b1);
    m.in_valid = 1'b1; m.in_data = 32'd99; m.in_last = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_vld",   64'(m.out_valid), 64'd1);
      chk("bp_ready", 64'(m.in_ready), 64'd0);
      chk("bp_min",   64'(m.out_min), 64'd2);
      chk("bp_max",   64'(m.out_max), 64'd10);
      chk("bp_cnt",   64'(m.out_count), 64'd2);
      step();
    end
    m.in_valid = 1'b0; m.out_ready = 1'b1; #1;
    step();
    chk("bp_emit_once", 64'(m.out_valid), 64'd0);
    send(32'd4, 1'b1);
    expect_rec("bp_next", 32'd4, 32'd4, 16'd1);

    // 20-beat packet: 16-bit counter gives 20, 4-bit counter saturates at 15.
    for (int i = 0; i < 20; i++)
      send((i == 7) ? 32'd1 : (i == 13) ? 32'd1000 : 32'(50 + i), (i == 19));
    chk("sat4_cnt", 64'(m4.out_count), 64'd15);
    chk("sat4_min", 64'(m4.out_min), 64'd1);
    chk("sat4_max", 64'(m4.out_max), 64'd1000);
    chk("sat4_vld", 64'(m4.out_valid), 64'd1);
    expect_rec("cnt20", 32'd1, 32'd1000, 16'd20);

    // Reset in ACC after two beats, then a clean packet.
    send(32'd50, 1'b0); send(32'd60, 1'b0);
    rst = 1'b1; step();
    chk("racc_vld", 64'(m.out_valid), 64'd0);
    chk("racc_cnt", 64'(m.out_count), 64'd0);
    rst = 1'b0; #1;
    send(32'd9, 1'b1);
    expect_rec("racc", 32'd9, 32'd9, 16'd1);

    // Reset while a record is held.
    m.out_ready = 1'b0;
    send(32'd1, 1'b1);
    chk("rout_pre", 64'(m.out_valid), 64'd1);
    rst = 1'b1; step();
    chk("rout_vld", 64'(m.out_valid), 64'd0);
    rst = 1'b0; m.out_ready = 1'b1; #1;
    send(32'd8, 1'b1);
    expect_rec("rout", 32'd8, 32'd8, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
